// File: rtl/rf_wb_sched.sv
// Purpose: register-file issue scoreboard and round-robin write-back arbiter.
// Latency: a granted write-back reaches rd_we/rd_waddr/rd_wdata one cycle later;
//          iss_ready and wb_ready are combinational.
// Backpressure: iss_ready drops on RAW/WAW hazards; one write-back granted per
//               cycle via one-hot wb_ready; flush withholds both.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush               clears scoreboard, squashes the pending write, blocks issue/grant
//   iss_valid/iss_ready issue handshake; iss_rd_we/iss_rd/iss_rs1/iss_rs2 describe the instruction
//   wb_valid/wb_ready   per-requester write-back handshake; wb_rd/wb_data packed per requester
//   rd_we/rd_waddr/rd_wdata  registered register-file write port
//   pending             registered count of busy registers
module rf_wb_sched #(
  parameter int NREQ  = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int NREGS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               iss_valid,
  input  logic               iss_rd_we,
  input  logic [AW-1:0]      iss_rd,
  input  logic [AW-1:0]      iss_rs1,
  input  logic [AW-1:0]      iss_rs2,
  output logic               iss_ready,
  input  logic [NREQ-1:0]    wb_valid,
  input  logic [NREQ*AW-1:0] wb_rd,
  input  logic [NREQ*DW-1:0] wb_data,
  output logic [NREQ-1:0]    wb_ready,
  output logic               rd_we,
  output logic [AW-1:0]      rd_waddr,
  output logic [DW-1:0]      rd_wdata,
  output logic [AW:0]        pending
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] free_vec;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    cand;
  logic             gnt_any;
  logic [AW-1:0]    sel_rd;
  logic [DW-1:0]    sel_data;
  logic             iss_acc;
  logic [AW:0]      pending_nxt;

  // A register being written this cycle is free: the register file bypasses
  // same-cycle writes to readers. x0 is always free.
  always_comb begin
    free_vec = ~busy;
    if (rd_we) free_vec[rd_waddr] = 1'b1;
    free_vec[0] = 1'b1;
  end

  assign iss_ready = !flush && free_vec[iss_rs1] && free_vec[iss_rs2] &&
                     (!iss_rd_we || free_vec[iss_rd]);

  assign iss_acc = iss_valid && iss_ready && iss_rd_we && (iss_rd != '0);

  // Round-robin: scan starting one past the last grant, wrapping at NREQ.
  // Only wb_valid and ptr feed the grant, never wb_data.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = ptr;
    wb_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!gnt_any && wb_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (flush) gnt_any = 1'b0;
    if (gnt_any) wb_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_rd   = wb_rd[i*AW +: AW];
        sel_data = wb_data[i*DW +: DW];
      end
    end
  end

  // Clear from the write retiring now, then set from the issue: a new
  // producer for the same register must keep it busy.
  always_comb begin
    busy_nxt = busy;
    if (rd_we) busy_nxt[rd_waddr] = 1'b0;
    if (iss_acc) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    if (flush) busy_nxt = '0;
  end

  always_comb begin
    pending_nxt = '0;
    for (int i = 1; i < NREGS; i++) begin
      pending_nxt = pending_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      ptr      <= PW'(NREQ - 1);
      rd_we    <= 1'b0;
      rd_waddr <= '0;
      rd_wdata <= '0;
      pending  <= '0;
    end else begin
      busy    <= busy_nxt;
      pending <= pending_nxt;
      // gnt_any is already forced low during flush, so this also squashes the write.
      rd_we   <= gnt_any && (sel_rd != '0);
      if (gnt_any) begin
        ptr      <= gnt_idx;
        rd_waddr <= sel_rd;
        rd_wdata <= sel_data;
      end
    end
  end

endmodule
